// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 keyboard transmitter.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        GAP
    } ps2_state_e;

    // Start + 8 data + parity + stop
    localparam int unsigned FRAME_BITS = 11;

    function automatic int unsigned half_period(input int unsigned clk_hz,
                                                input int unsigned ps2_hz);
        return clk_hz / (2 * ps2_hz);
    endfunction

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_kbd_tx_fifo.sv
// Synchronous byte FIFO with peek at the head; pushes while full are ignored.
module ps2_tx_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  logic [7:0] din_i,
    input  logic       pop_i,
    output logic [7:0] head_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers wrap modulo depth; count tracks occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter: queues bytes and sends 11-bit frames,
// aborting and later resending a frame when the host inhibits the clock.
module ps2_kbd_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned PS2_HZ     = 12_500,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       overflow,
    output logic       ps2_clk_out,
    output logic       ps2_dat_out,
    input  logic       ps2_clk_in,
    output logic       busy
);

    localparam int unsigned HALF     = half_period(CLK_HZ, PS2_HZ);
    localparam int unsigned CW       = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [3:0] LAST_IDX  = 4'(FRAME_BITS - 1);

    ps2_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    idx_q;
    logic [7:0]    byte_q;
    logic          clk_q;
    logic          dat_q;
    logic          sync1_q, sync2_q;
    logic          hist1_q, hist2_q;
    logic          busy_q;
    logic          ovf_q;

    logic          fifo_full, fifo_empty;
    logic [7:0]    fifo_head;
    logic          push, pop, inhibit, gap_done;

    function automatic logic frame_bit(input logic [3:0] idx, input logic [7:0] b);
        logic [2:0] bi;
        bi = 3'(idx - 4'd1);
        if (idx == 4'd0) return 1'b0;
        if (idx <= 4'd8) return b[bi];
        if (idx == 4'd9) return odd_parity(b);
        return 1'b1;
    endfunction

    assign data_ready  = ~fifo_full;
    assign push        = data_valid & ~fifo_full;
    assign pop         = (state_q == HIGH) && (cnt_q == '0) && (idx_q == LAST_IDX) && !inhibit;
    assign gap_done    = (state_q == GAP) && (cnt_q == '0) && (idx_q != 4'd0);
    // The synchronised bus lags our own clock by two cycles; only trust a low
    // reading once we have been releasing the clock for that long.
    assign inhibit     = ~sync2_q & clk_q & hist2_q;
    assign ps2_clk_out = clk_q;
    assign ps2_dat_out = dat_q;
    assign busy        = busy_q;
    assign overflow    = ovf_q;

    ps2_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .din_i   (data_in),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Two-flop synchroniser for the bus clock, plus matching history of our drive
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist1_q <= 1'b1;
            hist2_q <= 1'b1;
        end else begin
            sync1_q <= ps2_clk_in;
            sync2_q <= sync1_q;
            hist1_q <= clk_q;
            hist2_q <= hist1_q;
        end
    end

    // Registered status: busy while a frame or queued byte exists, overflow on dropped push
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            busy_q <= push | ~fifo_empty | ((state_q != IDLE) & ~gap_done);
            ovf_q  <= data_valid & fifo_full;
        end
    end

    // Frame FSM with registered line drive; GAP runs two half periods via idx_q
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            byte_q  <= '0;
            clk_q   <= 1'b1;
            dat_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty && !inhibit) begin
                        state_q <= SETUP;
                        byte_q  <= fifo_head;
                        idx_q   <= '0;
                        cnt_q   <= HALF_M1;
                        dat_q   <= 1'b0;
                        clk_q   <= 1'b1;
                    end
                end
                SETUP, HIGH: begin
                    if (inhibit) begin
                        state_q <= GAP;
                        idx_q   <= '0;
                        cnt_q   <= HALF_M1;
                        clk_q   <= 1'b1;
                        dat_q   <= 1'b1;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (state_q == SETUP) begin
                        state_q <= LOW;
                        clk_q   <= 1'b0;
                        cnt_q   <= HALF_M1;
                    end else if (idx_q == LAST_IDX) begin
                        state_q <= GAP;
                        idx_q   <= '0;
                        cnt_q   <= HALF_M1;
                        dat_q   <= 1'b1;
                    end else begin
                        state_q <= SETUP;
                        idx_q   <= idx_q + 1'b1;
                        dat_q   <= frame_bit(idx_q + 1'b1, byte_q);
                        cnt_q   <= HALF_M1;
                    end
                end
                LOW: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q <= HIGH;
                        clk_q   <= 1'b1;
                        cnt_q   <= HALF_M1;
                    end
                end
                GAP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (idx_q == 4'd0) begin
                        idx_q <= 4'd1;
                        cnt_q <= HALF_M1;
                    end else begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    clk_q   <= 1'b1;
                    dat_q   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Scoreboard bench for ps2_kbd_tx: pushes bytes, a bus monitor decodes frames
// at clock falls and compares them with reference frames built from the bytes.
`timescale 1ns/1ps
module tb_ps2_kbd_tx;

    localparam int unsigned CLK_HZ = 8_000;
    localparam int unsigned PS2_HZ = 1_000;
    localparam int unsigned H      = CLK_HZ / (2 * PS2_HZ);
    localparam int unsigned DEPTH  = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = '0;
    logic       data_valid = 1'b0;
    logic       data_ready, overflow, ps2_clk_out, ps2_dat_out, busy;
    logic       host_clk = 1'b1;
    logic       ps2_clk_in;

    // Open-collector bus: either side can hold the clock low
    assign ps2_clk_in = ps2_clk_out & host_clk;

    ps2_kbd_tx #(.CLK_HZ(CLK_HZ), .PS2_HZ(PS2_HZ), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .overflow    (overflow),
        .ps2_clk_out (ps2_clk_out),
        .ps2_dat_out (ps2_dat_out),
        .ps2_clk_in  (ps2_clk_in),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  exp_q[$];
    int          model_cnt = 0;
    int          exp_ovf = 0;
    int          ovf_seen = 0;
    int          aborts = 0;
    int          total_falls = 0;
    int unsigned start_cyc[$];

    task automatic check(input string name, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [10:0] ref_frame(input logic [7:0] b);
        int ones;
        logic par;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        par = (ones % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, b, 1'b0};
    endfunction

    // Bus monitor: collect bits at clock falls, score complete frames,
    // discard partial frames once the clock has idled too long
    logic [10:0] got_bits;
    int          nbits = 0;
    int          high_run = 0;
    logic        prev_clk = 1'b1;
    int unsigned cur_start = 0;
    int unsigned last_end = 0;
    logic        have_last = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            nbits = 0;
            high_run = 0;
            prev_clk = 1'b1;
        end else begin
            if (overflow) ovf_seen++;
            if (prev_clk && !ps2_clk_out) begin
                total_falls++;
                if (nbits == 0) begin
                    cur_start = cyc;
                    if (have_last) check("gap_min", (cyc - last_end >= 5*H+1), 1);
                end
                got_bits[nbits] = ps2_dat_out;
                nbits++;
                if (nbits == 11) begin
                    nbits = 0;
                    last_end = cyc;
                    have_last = 1'b1;
                    start_cyc.push_back(cur_start);
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", got_bits, 0);
                    end else begin
                        check("frame", got_bits, ref_frame(exp_q.pop_front()));
                        model_cnt--;
                    end
                end
            end
            high_run = ps2_clk_out ? high_run + 1 : 0;
            if (nbits != 0 && high_run > 2*H+2) begin
                aborts++;
                nbits = 0;
            end
            prev_clk = ps2_clk_out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        logic acc;
        acc = (model_cnt < DEPTH);
        check("data_ready", data_ready, acc);
        data_in = b;
        data_valid = 1'b1;
        if (acc) begin
            exp_q.push_back(b);
            model_cnt++;
        end else begin
            exp_ovf++;
        end
        tick();
        data_valid = 1'b0;
        check("overflow", overflow, !acc);
    endtask

    task automatic wait_drain(input int unsigned limit);
        int unsigned n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < limit) begin
            tick();
            n++;
        end
        check("drain_timeout", (n < limit), 1);
    endtask

    task automatic wait_falls(input int target, input int unsigned limit);
        int unsigned n;
        n = 0;
        while (total_falls < target && n < limit) begin
            tick();
            n++;
        end
        check("falls_timeout", (n < limit), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n0;
        int unsigned n;
        int          base;
        int          ab0;

        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_clk", ps2_clk_out, 1);
        check("rst_dat", ps2_dat_out, 1);
        check("rst_ready", data_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);

        // Single byte: latency, first fall and busy drop timing
        n0 = cyc;
        base = total_falls;
        push(8'h1C);
        check("busy_n1", busy, 1);
        check("dat_n1", ps2_dat_out, 1);
        tick();
        check("start_n2", ps2_dat_out, 0);
        n = 0;
        while (busy && n < 60*H) begin
            tick();
            n++;
        end
        check("busy_drop_cycle", cyc, n0 + 2 + 35*H);
        check("first_fall_cycle", start_cyc[$], n0 + 2 + H);
        check("falls_1c", total_falls - base, 11);

        // All-zero byte: parity 1, exactly 11 falls
        base = total_falls;
        push(8'h00);
        wait_drain(60*H);
        check("falls_00", total_falls - base, 11);

        // Back-to-back bytes: order and start spacing
        push(8'hF0);
        push(8'h1C);
        wait_drain(120*H);
        check("start_spacing", start_cyc[$] - start_cyc[$-1], 35*H + 1);

        // Fill with the bus inhibited, one extra push overflows
        host_clk = 1'b0;
        repeat (5) tick();
        for (int i = 0; i < 17; i++) push(8'($urandom));
        check("ready_full", data_ready, 0);
        check("busy_inhibited", busy, 1);
        tick();
        check("ovf_pulses", ovf_seen, 1);
        host_clk = 1'b1;
        wait_drain(16*(36*H+2) + 100);

        // Inhibit during bit 5 of 0xAA: abort, release, resend once
        base = total_falls;
        ab0 = aborts;
        push(8'hAA);
        wait_falls(base + 5, 40*H);
        n = 0;
        while (!ps2_clk_out && n < 4*H) begin
            tick();
            n++;
        end
        repeat (H) tick();
        host_clk = 1'b0;
        repeat (3) tick();
        check("abort_clk", ps2_clk_out, 1);
        check("abort_dat", ps2_dat_out, 1);
        repeat (30) tick();
        host_clk = 1'b1;
        wait_drain(80*H);
        check("abort_count", aborts - ab0, 1);

        // Reset mid-frame: immediate release, flush, nothing afterwards
        base = total_falls;
        push(8'h5A);
        push(8'h33);
        wait_falls(base + 3, 40*H);
        reset = 1'b1;
        exp_q.delete();
        model_cnt = 0;
        #1;
        check("midrst_clk", ps2_clk_out, 1);
        check("midrst_dat", ps2_dat_out, 1);
        check("midrst_ready", data_ready, 1);
        check("midrst_busy", busy, 0);
        tick();
        tick();
        reset = 1'b0;
        base = total_falls;
        repeat (40*H) tick();
        check("no_frame_after_rst", total_falls - base, 0);
        check("idle_after_rst", busy, 0);

        // Random bytes with random spacing
        for (int i = 0; i < 8; i++) begin
            push(8'($urandom));
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_drain(8*(36*H+2) + 100);

        check("queue_empty", exp_q.size(), 0);
        check("ovf_total", ovf_seen, exp_ovf);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
